// File: rtl/alarm_siren_ctrl_pkg.sv
// Shared types and default timing constants for the alarm siren controller.
// State encodings are fixed so the keypad firmware can decode the debug state.
package alarm_siren_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED  = 3'd0,
    ST_EXIT_DLY  = 3'd1,
    ST_ARMED     = 3'd2,
    ST_ENTRY_DLY = 3'd3,
    ST_SOUNDING  = 3'd4
  } state_e;

  localparam int DEF_EXIT_TICKS  = 8;
  localparam int DEF_ENTRY_TICKS = 4;
  localparam int DEF_SIREN_TICKS = 16;
  localparam int DEF_CNT_W       = 5;

  // States in which the zone inputs are honoured and accumulated.
  function automatic logic is_watching(state_e s);
    return (s == ST_ARMED) || (s == ST_ENTRY_DLY) || (s == ST_SOUNDING);
  endfunction

endpackage

// File: rtl/alarm_siren_ctrl_if.sv
// Signal bundle between the sensor/keypad side and the siren controller.
// No valid/ready pair: all inputs are levels sampled every Clock, except Tick,
// a one-Clock strobe; outputs are registered and valid every cycle.
interface alarm_siren_ctrl_if;
  import alarm_siren_ctrl_pkg::*;

  logic       Enable;
  logic       Alarm_State;
  logic [3:0] Sensor;
  logic       Tick;
  logic       Siren;
  logic       Armed_Led;
  logic       Entry_Pending;
  logic       Exit_Pending;
  logic [3:0] Zone_Latch;
  state_e     State;

  modport master (
    output Enable, Alarm_State, Sensor, Tick,
    input  Siren, Armed_Led, Entry_Pending, Exit_Pending, Zone_Latch, State
  );

  modport slave (
    input  Enable, Alarm_State, Sensor, Tick,
    output Siren, Armed_Led, Entry_Pending, Exit_Pending, Zone_Latch, State
  );
endinterface

// File: rtl/alarm_siren_ctrl_tick_timer.sv
// Loadable down-counter stepped by Tick; Expired flags a Tick seen at zero,
// so a load of N-1 expires on exactly the Nth Tick.
module alarm_siren_ctrl_tick_timer #(
  parameter int CNT_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic [CNT_W-1:0] Load_Val,
  input  logic             Tick,
  output logic             Expired
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (Load) begin
      count_d = Load_Val;
    end else if (Tick && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Expired = Tick && (count_q == '0);

endmodule

// File: rtl/alarm_siren_ctrl.sv
// Alarm sequencer: exit delay, front-door entry delay, timed siren with
// auto-rearm, and a first-cause zone latch for the keypad display.
module alarm_siren_ctrl
  import alarm_siren_ctrl_pkg::*;
#(
  parameter int EXIT_TICKS  = DEF_EXIT_TICKS,
  parameter int ENTRY_TICKS = DEF_ENTRY_TICKS,
  parameter int SIREN_TICKS = DEF_SIREN_TICKS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic               Clock,
  input  logic               Reset,
  alarm_siren_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_TICKS - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_TICKS - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TICKS - 1);

  state_e           state_q, state_d;
  logic [3:0]       zone_q, zone_d;
  logic             siren_q, armed_q, entry_q, exit_q;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             timed_state;
  logic             expired;

  // Only the delay/sounding states consume Tick; elsewhere the counter idles.
  assign timed_state = (state_q == ST_EXIT_DLY) || (state_q == ST_ENTRY_DLY) ||
                       (state_q == ST_SOUNDING);

  alarm_siren_ctrl_tick_timer #(.CNT_W(CNT_W)) u_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .Load     (load),
    .Load_Val (load_val),
    .Tick     (bus.Tick && timed_state),
    .Expired  (expired)
  );

  always_comb begin
    state_d  = state_q;
    zone_d   = zone_q;
    load     = 1'b0;
    load_val = '0;
    if (is_watching(state_q)) begin
      zone_d = zone_q | bus.Sensor;
    end
    case (state_q)
      ST_DISARMED: begin
        state_d  = ST_EXIT_DLY;
        load     = 1'b1;
        load_val = EXIT_LOAD;
        zone_d   = '0;
      end
      ST_EXIT_DLY: begin
        if (expired) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        // Any non-door zone wins over the door, even when both open together.
        if (bus.Alarm_State && (|bus.Sensor[3:1])) begin
          state_d  = ST_SOUNDING;
          load     = 1'b1;
          load_val = SIREN_LOAD;
        end else if (bus.Alarm_State && (bus.Sensor == 4'b0001)) begin
          state_d  = ST_ENTRY_DLY;
          load     = 1'b1;
          load_val = ENTRY_LOAD;
        end
      end
      ST_ENTRY_DLY: begin
        if (expired || (|bus.Sensor[3:1])) begin
          state_d  = ST_SOUNDING;
          load     = 1'b1;
          load_val = SIREN_LOAD;
        end
      end
      ST_SOUNDING: begin
        if (expired) state_d = ST_ARMED;
      end
      default: state_d = ST_DISARMED;
    endcase
    if (!bus.Enable) begin
      state_d = ST_DISARMED;
      load    = 1'b0;
      if (state_q == ST_DISARMED) zone_d = zone_q;
    end
  end

  // Outputs are registered decodes of the next state so they align with state_q.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_DISARMED;
      zone_q  <= '0;
      siren_q <= 1'b0;
      armed_q <= 1'b0;
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      zone_q  <= zone_d;
      siren_q <= (state_d == ST_SOUNDING);
      armed_q <= is_watching(state_d);
      entry_q <= (state_d == ST_ENTRY_DLY);
      exit_q  <= (state_d == ST_EXIT_DLY);
    end
  end

  assign bus.Siren         = siren_q;
  assign bus.Armed_Led     = armed_q;
  assign bus.Entry_Pending = entry_q;
  assign bus.Exit_Pending  = exit_q;
  assign bus.Zone_Latch    = zone_q;
  assign bus.State         = state_q;

endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// Directed bench for alarm_siren_ctrl: a vector table for reset and the exit
// delay, then hand-written sequences for the multi-cycle timing corners.
module tb_alarm_siren_ctrl;
  import alarm_siren_ctrl_pkg::*;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] sen;
    logic       tick;
    logic       siren;
    logic       armed;
    logic       entry;
    logic       exit_p;
    logic [3:0] zone;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[13];

  alarm_siren_ctrl_if bus ();

  alarm_siren_ctrl dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply one cycle of inputs, sample #1 after the rising edge.
  task automatic step(input logic r, input logic en, input logic [3:0] sen, input logic tk);
    rst             = r;
    bus.Enable      = en;
    bus.Sensor      = sen;
    bus.Alarm_State = (|sen) & en;
    bus.Tick        = tk;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard compare of the whole output word {Siren,Armed,Entry,Exit,Zone}.
  task automatic check(input string name, input logic s, input logic a, input logic e,
                       input logic x, input logic [3:0] z);
    logic [7:0] got;
    logic [7:0] exp;
    got = {bus.Siren, bus.Armed_Led, bus.Entry_Pending, bus.Exit_Pending, bus.Zone_Latch};
    exp = {s, a, e, x, z};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got siren/armed/entry/exit/zone=%b, expected %b", name, got, exp);
    end
  endtask

  // From DISARMED: arm, run the full exit delay, land in ARMED with zone 0.
  task automatic go_armed(input string name);
    step(0, 1, 4'b0000, 0);
    check({name, "_exit_start"}, 0, 0, 0, 1, 4'b0000);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 4'b0000, 1);
      if (i < 8) check({name, "_exit_tick"}, 0, 0, 0, 1, 4'b0000);
      else       check({name, "_armed"}, 0, 1, 0, 0, 4'b0000);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.Enable = 1'b0;
    bus.Sensor = 4'b0000;
    bus.Alarm_State = 1'b0;
    bus.Tick = 1'b0;

    // rst en sen tick | siren armed entry exit zone
    vecs[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[2]  = '{1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};
    for (int i = 3; i <= 9; i++)
      vecs[i] = '{1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[10] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
    vecs[11] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
    vecs[12] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].sen, vecs[i].tick);
      check($sformatf("vec%0d", i), vecs[i].siren, vecs[i].armed, vecs[i].entry,
            vecs[i].exit_p, vecs[i].zone);
    end

    // Door then disarm inside the entry delay.
    go_armed("t3");
    step(0, 1, 4'b0001, 0);
    check("t3_entry", 0, 1, 1, 0, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 4'b0001, 1);
      check("t3_entry_tick", 0, 1, 1, 0, 4'b0001);
    end
    step(0, 0, 4'b0001, 0);
    check("t3_disarmed", 0, 0, 0, 0, 4'b0001);

    // Door, full entry delay, full siren, auto-rearm.
    go_armed("t4");
    step(0, 1, 4'b0001, 0);
    check("t4_entry", 0, 1, 1, 0, 4'b0001);
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 4'b0000, 1);
      if (i < 4) check("t4_entry_tick", 0, 1, 1, 0, 4'b0001);
      else       check("t4_siren_on", 1, 1, 0, 0, 4'b0001);
    end
    step(0, 1, 4'b0000, 0);
    check("t4_no_tick_hold", 1, 1, 0, 0, 4'b0001);
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 4'b0000, 1);
      if (i < 16) check("t4_siren_tick", 1, 1, 0, 0, 4'b0001);
      else        check("t4_rearmed", 0, 1, 0, 0, 4'b0001);
    end

    // Interior zone pulse, latch held while disarmed, cleared on re-arm.
    step(0, 0, 4'b0000, 0);
    check("t5_disarm", 0, 0, 0, 0, 4'b0001);
    go_armed("t5");
    step(0, 1, 4'b1000, 0);
    check("t5_siren", 1, 1, 0, 0, 4'b1000);
    step(0, 0, 4'b0000, 0);
    check("t5_disarmed", 0, 0, 0, 0, 4'b1000);
    step(0, 0, 4'b0000, 1);
    check("t5_latch_held", 0, 0, 0, 0, 4'b1000);
    step(0, 1, 4'b0000, 0);
    check("t5_rearm_clear", 0, 0, 0, 1, 4'b0000);
    for (int i = 0; i < 8; i++) step(0, 1, 4'b0000, 1);
    check("t5_armed", 0, 1, 0, 0, 4'b0000);

    // Second zone opening mid entry delay sounds at once.
    step(0, 1, 4'b0001, 0);
    step(0, 1, 4'b0001, 1);
    step(0, 1, 4'b0001, 1);
    check("t6_entry_2ticks", 0, 1, 1, 0, 4'b0001);
    step(0, 1, 4'b0011, 0);
    check("t6_sounding", 1, 1, 0, 0, 4'b0011);

    // Reset mid-sounding.
    step(1, 1, 4'b0011, 0);
    check("t1_reset", 0, 0, 0, 0, 4'b0000);
    step(0, 1, 4'b0000, 0);
    check("t1_rearm", 0, 0, 0, 1, 4'b0000);
    for (int i = 0; i < 8; i++) step(0, 1, 4'b0000, 1);
    check("t1_armed", 0, 1, 0, 0, 4'b0000);

    // Entry expiry coinciding with Enable fall goes to DISARMED.
    step(0, 1, 4'b0001, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 4'b0001, 1);
    check("sim_entry_last", 0, 1, 1, 0, 4'b0001);
    step(0, 0, 4'b0001, 1);
    check("sim_expiry_disarm", 0, 0, 0, 0, 4'b0001);

    // Door plus another zone together in ARMED goes straight to SOUNDING.
    go_armed("sim2");
    step(0, 1, 4'b0101, 0);
    check("sim_door_and_zone", 1, 1, 0, 0, 4'b0101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
